// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and default sizing for the FIFO read-port burst scheduler.
package fifo_rd_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int FRS_NREQ = 4;
  localparam int FRS_LENW = 4;

endpackage

// File: rtl/fifo_rd_sched_rr.sv
// rr_arbiter: round-robin pick among req, searching upward from the index
// after ptr (the last granted requester) and wrapping. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IDW-1:0]  win_idx
);

  // Walk the ring farthest-first so that the nearest requester after ptr
  // is the last writer and therefore wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        win_oh  = '0;
        win_oh[(int'(ptr) + k) % NREQ] = 1'b1;
        win_idx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: grants the FIFO read port to one of NREQ requesters for a
// committed burst of len+1 beats. A beat is any XFER cycle with the FIFO
// non-empty. Optional empty-stall timeout is enabled by defining the macro
// FRS_TIMEOUT_EN; without it a burst waits on rempty forever and abort is 0.
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int NREQ = FRS_NREQ,
  parameter int LENW = FRS_LENW,
  parameter int TOUT = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic                 rempty,
  output logic                 rinc,
  output logic [NREQ-1:0]      gnt,
  output logic                 beat_vld,
  output logic                 beat_last,
  output logic [NREQ-1:0]      done,
  output logic                 abort
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = LENW + 1;

  state_e          state_q, state_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_idx;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef FRS_TIMEOUT_EN
  localparam int SW = $clog2(TOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          abort_c;
  assign abort = abort_c;
`else
  assign abort = 1'b0;
`endif

  // The read strobe is the grant itself; a word moves only when non-empty.
  assign beat_vld = rinc & ~rempty;

  // Next-state and outputs: IDLE arbitrates for one cycle, XFER drains the burst.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rinc      = 1'b0;
    gnt       = '0;
    beat_last = 1'b0;
    done      = '0;
`ifdef FRS_TIMEOUT_EN
    stall_d   = stall_q;
    abort_c   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = XFER;
          id_d    = win_idx;
          ptr_d   = win_idx;
          len_d   = req_len[int'(win_idx)*LENW +: LENW];
          cnt_d   = '0;
`ifdef FRS_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      XFER: begin
        rinc      = 1'b1;
        gnt[id_q] = 1'b1;
        if (!rempty) begin
`ifdef FRS_TIMEOUT_EN
          stall_d = '0;
`endif
          if (cnt_q == {1'b0, len_q}) begin
            beat_last  = 1'b1;
            done[id_q] = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef FRS_TIMEOUT_EN
        else if (stall_q == SW'(TOUT - 1)) begin
          // TOUT-th consecutive empty cycle: give the port back, flag abort.
          done[id_q] = 1'b1;
          abort_c    = 1'b1;
          state_d    = IDLE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; pointer resets to the last index so requester 0 wins first.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FRS_TIMEOUT_EN
  // Consecutive-empty counter, only present when the timeout is built in.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) stall_q <= '0;
    else         stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: per-cycle vector table plus hand-written
// reset-mid-burst and stall/timeout sequences. NREQ=4, LENW=4, TOUT=16.
module tb_fifo_rd_sched;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_len = '0;
  logic        rempty = 1'b0;
  logic        rinc, beat_vld, beat_last, abort;
  logic [3:0]  gnt, done;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  fifo_rd_sched #(.NREQ(4), .LENW(4), .TOUT(16)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .req       (req),
    .req_len   (req_len),
    .rempty    (rempty),
    .rinc      (rinc),
    .gnt       (gnt),
    .beat_vld  (beat_vld),
    .beat_last (beat_last),
    .done      (done),
    .abort     (abort)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic        rempty;
    logic [3:0]  gnt;
    logic        rinc;
    logic        bv;
    logic        last;
    logic [3:0]  done;
  } vec_t;

  localparam int NV = 27;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    req     = '0;
    req_len = '0;
    rempty  = 1'b0;
    #1;
    chk("rst gnt",  32'(gnt), 0);
    chk("rst rinc", 32'(rinc), 0);
    chk("rst done", 32'(done), 0);
    chk("rst abort", 32'(abort), 0);
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // rst, req, len, rempty | gnt, rinc, bv, last, done
    // single requester, 4-beat burst
    tv[0]  = '{1'b1, 4'b0001, 16'h3333, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[1]  = '{1'b0, 4'b0001, 16'h3333, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000};
    tv[2]  = '{1'b0, 4'b0001, 16'h3333, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000};
    tv[3]  = '{1'b0, 4'b0001, 16'h3333, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000};
    tv[4]  = '{1'b0, 4'b0001, 16'h3333, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001};
    tv[5]  = '{1'b0, 4'b0000, 16'h3333, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    // all requesting, single-beat bursts, round-robin 0,1,2,3,0
    tv[6]  = '{1'b1, 4'b1111, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[7]  = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001};
    tv[8]  = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[9]  = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010};
    tv[10] = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[11] = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100};
    tv[12] = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[13] = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000};
    tv[14] = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[15] = '{1'b0, 4'b1111, 16'h0000, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001};
    // requester 2, len=2, rempty 0,1,1,0,0
    tv[16] = '{1'b1, 4'b0100, 16'h0200, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[17] = '{1'b0, 4'b0000, 16'h0200, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000};
    tv[18] = '{1'b0, 4'b0000, 16'h0200, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000};
    tv[19] = '{1'b0, 4'b0000, 16'h0200, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000};
    tv[20] = '{1'b0, 4'b0000, 16'h0200, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000};
    tv[21] = '{1'b0, 4'b0000, 16'h0200, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100};
    tv[22] = '{1'b0, 4'b0000, 16'h0200, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    // requester 1, len=1, drops req and scribbles req_len after grant
    tv[23] = '{1'b1, 4'b0010, 16'h0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    tv[24] = '{1'b0, 4'b0000, 16'hFFFF, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000};
    tv[25] = '{1'b0, 4'b0000, 16'hFFFF, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010};
    tv[26] = '{1'b0, 4'b0000, 16'hFFFF, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};

    for (int i = 0; i < NV; i++) begin
      if (tv[i].rst) do_reset();
      @(negedge rclk);
      req     = tv[i].req;
      req_len = tv[i].len;
      rempty  = tv[i].rempty;
      #1;
      chk($sformatf("v%0d gnt", i),  32'(gnt),       32'(tv[i].gnt));
      chk($sformatf("v%0d rinc", i), 32'(rinc),      32'(tv[i].rinc));
      chk($sformatf("v%0d bv", i),   32'(beat_vld),  32'(tv[i].bv));
      chk($sformatf("v%0d last", i), 32'(beat_last), 32'(tv[i].last));
      chk($sformatf("v%0d done", i), 32'(done),      32'(tv[i].done));
      chk($sformatf("v%0d abort", i), 32'(abort),    0);
    end

    // Reset mid-burst: outputs drop at once, then requester 0 wins again
    // even though the pre-reset pointer would have favoured requester 1.
    do_reset();
    @(negedge rclk);
    req = 4'b0001; req_len = 16'h3333; rempty = 1'b0;
    @(negedge rclk);
    req = '0;
    #1;
    chk("mid gnt pre", 32'(gnt), 32'h1);
    @(posedge rclk);
    #3;
    rrst_n = 1'b0;
    #1;
    chk("mid rst gnt",  32'(gnt), 0);
    chk("mid rst rinc", 32'(rinc), 0);
    chk("mid rst done", 32'(done), 0);
    @(negedge rclk);
    rrst_n = 1'b1; req = 4'b1111; req_len = 16'h0000;
    #1;
    chk("post rst idle gnt", 32'(gnt), 0);
    @(negedge rclk);
    #1;
    chk("post rst winner", 32'(gnt), 32'h1);

    // Stall with rempty stuck high after grant.
    do_reset();
    @(negedge rclk);
    req = 4'b0001; req_len = 16'h0000; rempty = 1'b1;
    #1;
    bad = 0;
`ifdef FRS_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge rclk);
      req = '0;
      #1;
      if (k < 16) begin
        if (done != 0 || abort != 0 || rinc != 1'b1) bad++;
      end else begin
        chk("tout done",  32'(done), 32'h1);
        chk("tout abort", 32'(abort), 1);
        chk("tout last",  32'(beat_last), 0);
      end
    end
    chk("tout early exit", 32'(bad), 0);
    @(negedge rclk);
    #1;
    chk("tout idle rinc", 32'(rinc), 0);
    chk("tout idle gnt",  32'(gnt), 0);
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge rclk);
      req = '0;
      #1;
      if (done != 0 || abort != 0 || rinc != 1'b1 || gnt != 4'b0001) bad++;
    end
    chk("stall no exit", 32'(bad), 0);
    rempty = 1'b0;
    #1;
    chk("stall release last", 32'(beat_last), 1);
    chk("stall release done", 32'(done), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
